// File: rtl/mat_vec_res_reader_pkg.sv
// Shared definitions for the GF(256) matrix-vector result reader:
// FSM encoding, parameter-set mapping and word/byte count derivations.
package mat_vec_res_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PS_L1 = 2'd0,
        PS_L3 = 2'd1,
        PS_L5 = 2'd2
    } param_set_t;

    function automatic int n_words(input int res_bytes, input int n_gf);
        return (res_bytes + n_gf - 32'sd1) / n_gf;
    endfunction

    function automatic int last_word_bytes(input int res_bytes, input int n_gf);
        return res_bytes - (n_words(res_bytes, n_gf) - 32'sd1) * n_gf;
    endfunction

    function automatic int res_bytes_of(input param_set_t ps);
        case (ps)
            PS_L1:   return 32'sd126;
            PS_L3:   return 32'sd193;
            PS_L5:   return 32'sd278;
            default: return 32'sd126;
        endcase
    endfunction

    // Never collapses to a zero-width vector when only one entry exists.
    function automatic int addr_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/mat_vec_res_reader.sv
// Drains the multiplier result buffer word by word and serialises each word
// MSB-first into a valid/ready byte stream, dropping last-word padding.
module mat_vec_res_reader
    import mat_vec_res_reader_pkg::*;
#(
    parameter int N_GF      = 8,
    parameter int RES_BYTES = 126
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_start,
    output logic                                        o_res_en,
    output logic [addr_width(n_words(RES_BYTES, N_GF))-1:0] o_res_addr,
    input  logic [N_GF*8-1:0]                           i_res,
    output logic [7:0]                                  o_byte,
    output logic                                        o_byte_valid,
    input  logic                                        i_byte_ready,
    output logic                                        o_byte_last,
    output logic                                        o_busy,
    output logic                                        o_done
);

    localparam int PROC_SIZE = N_GF * 8;
    localparam int N_WORDS   = n_words(RES_BYTES, N_GF);
    localparam int ADDR_W    = addr_width(N_WORDS);
    localparam int K_W       = addr_width(N_GF);
    localparam int B_W       = $clog2(RES_BYTES + 1);

    state_t                 state_r, state_s;
    logic [ADDR_W-1:0]      w_r, w_s;
    logic [K_W-1:0]         k_r, k_s;
    logic [B_W-1:0]         b_r, b_s;
    logic [PROC_SIZE-1:0]   shreg_r, shreg_s;
    logic                   hs_s, last_hs_s, word_end_s;
    logic                   res_en_s, valid_s, last_s, busy_s, done_s;
    logic [ADDR_W-1:0]      addr_s;
    logic [7:0]             byte_s;

    assign hs_s       = (state_r == ST_SHIFT) && i_byte_ready;
    assign last_hs_s  = hs_s && (b_r == B_W'(RES_BYTES - 1));
    assign word_end_s = hs_s && (k_r == K_W'(N_GF - 1));

    // State, counter and shift-register flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            w_r     <= '0;
            k_r     <= '0;
            b_r     <= '0;
            shreg_r <= '0;
        end else begin
            state_r <= state_s;
            w_r     <= w_s;
            k_r     <= k_s;
            b_r     <= b_s;
            shreg_r <= shreg_s;
        end
    end

    // Next-state logic plus next values of the counters and shift register.
    always_comb begin
        state_s = state_r;
        w_s     = w_r;
        k_s     = k_r;
        b_s     = b_r;
        shreg_s = shreg_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s = ST_READ;
                    w_s     = '0;
                    b_s     = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: state_s = ST_LOAD;
            ST_LOAD: begin
                state_s = ST_SHIFT;
                shreg_s = i_res;
                k_s     = '0;
            end
            ST_SHIFT: begin
                if (hs_s) begin
                    shreg_s = shreg_r << 8;
                    k_s     = k_r + K_W'(1);
                    b_s     = b_r + B_W'(1);
                    if (last_hs_s) begin
                        state_s = ST_DONE;
                    end else if (word_end_s) begin
                        state_s = ST_READ;
                        w_s     = w_r + ADDR_W'(1);
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the output flops line up with it.
    always_comb begin
        res_en_s = (state_s == ST_READ);
        addr_s   = res_en_s ? w_s : o_res_addr;
        valid_s  = (state_s == ST_SHIFT);
        byte_s   = valid_s ? shreg_s[PROC_SIZE-1 -: 8] : 8'd0;
        last_s   = valid_s && (b_s == B_W'(RES_BYTES - 1));
        busy_s   = (state_s != ST_IDLE);
        done_s   = (state_s == ST_DONE);
    end

    // Output registers; none of them has a combinational path from i_byte_ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_res_en     <= 1'b0;
            o_res_addr   <= '0;
            o_byte       <= 8'd0;
            o_byte_valid <= 1'b0;
            o_byte_last  <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_res_en     <= res_en_s;
            o_res_addr   <= addr_s;
            o_byte       <= byte_s;
            o_byte_valid <= valid_s;
            o_byte_last  <= last_s;
            o_busy       <= busy_s;
            o_done       <= done_s;
        end
    end

endmodule

// File: tb/tb_mat_vec_res_reader.sv
// Bench for mat_vec_res_reader: three instances (L1 defaults, L3 sizing, exact
// fit) fed from behavioural result memories and checked against a stream model.
module tb_mat_vec_res_reader;

    logic clk = 1'b0;
    logic rst, start, ready;
    int   sel;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] mem_a [16];
    logic [63:0] mem_b [25];
    logic [63:0] mem_c [1];

    logic start_a, start_b, start_c;
    logic en_a, en_b, en_c, val_a, val_b, val_c, last_a, last_b, last_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [3:0]  addr_a;
    logic [4:0]  addr_b;
    logic [0:0]  addr_c;
    logic [63:0] res_a, res_b, res_c;
    logic [7:0]  byte_a, byte_b, byte_c;

    logic       m_en, m_valid, m_last, m_busy, m_done;
    logic [7:0] m_addr, m_byte;

    always #5 clk = ~clk;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    mat_vec_res_reader #(.N_GF(8), .RES_BYTES(126)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_res_en(en_a), .o_res_addr(addr_a),
        .i_res(res_a), .o_byte(byte_a), .o_byte_valid(val_a), .i_byte_ready(ready),
        .o_byte_last(last_a), .o_busy(busy_a), .o_done(done_a));

    mat_vec_res_reader #(.N_GF(8), .RES_BYTES(193)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_res_en(en_b), .o_res_addr(addr_b),
        .i_res(res_b), .o_byte(byte_b), .o_byte_valid(val_b), .i_byte_ready(ready),
        .o_byte_last(last_b), .o_busy(busy_b), .o_done(done_b));

    mat_vec_res_reader #(.N_GF(8), .RES_BYTES(8)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_start(start_c), .o_res_en(en_c), .o_res_addr(addr_c),
        .i_res(res_c), .o_byte(byte_c), .o_byte_valid(val_c), .i_byte_ready(ready),
        .o_byte_last(last_c), .o_busy(busy_c), .o_done(done_c));

    // Registered one-cycle result-buffer reads.
    always @(posedge clk) begin
        if (en_a) res_a <= mem_a[addr_a];
        if (en_b) res_b <= mem_b[addr_b];
        if (en_c) res_c <= mem_c[addr_c];
    end

    always_comb begin
        case (sel)
            0: begin
                m_en = en_a; m_addr = {4'd0, addr_a}; m_byte = byte_a; m_valid = val_a;
                m_last = last_a; m_busy = busy_a; m_done = done_a;
            end
            1: begin
                m_en = en_b; m_addr = {3'd0, addr_b}; m_byte = byte_b; m_valid = val_b;
                m_last = last_b; m_busy = busy_b; m_done = done_b;
            end
            default: begin
                m_en = en_c; m_addr = {7'd0, addr_c}; m_byte = byte_c; m_valid = val_c;
                m_last = last_c; m_busy = busy_c; m_done = done_c;
            end
        endcase
    end

    function automatic int nbytes(input int s);
        return (s == 0) ? 126 : (s == 1) ? 193 : 8;
    endfunction

    function automatic int nwords(input int s);
        return (nbytes(s) + 7) / 8;
    endfunction

    // Stream byte i is byte (i mod 8) of word (i div 8), most significant first.
    function automatic logic [7:0] exp_byte(input int s, input int i);
        logic [63:0] wd;
        int          w, k;
        w = i / 8;
        k = i % 8;
        wd = (s == 0) ? mem_a[w] : (s == 1) ? mem_b[w] : mem_c[w];
        return wd[63 - 8 * k -: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_en"}, m_en, 0);
        chk({tag, "_addr"}, m_addr, 0);
        chk({tag, "_byte"}, m_byte, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_busy"}, m_busy, 0);
        chk({tag, "_done"}, m_done, 0);
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // One complete drain on instance s; mode picks the ready pattern.
    task automatic run(input int s, input int mode, input bit repulse);
        int         nb, nw, idx, stalls, cyc, done_cyc;
        bit         got_done, prev_stall, prev_last;
        logic [7:0] prev_byte;
        int         addr_q[$];
        nb = nbytes(s); nw = nwords(s);
        idx = 0; stalls = 0; cyc = 0; done_cyc = -1;
        got_done = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_byte = 8'd0;
        sel = s;
        @(posedge clk); #1;
        start = 1'b1;
        ready = ready_for(mode, 0);
        chk("busy_before_start", m_busy, 0);
        while (!got_done && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            start = repulse && (cyc == 5 || cyc == 40);
            ready = ready_for(mode, cyc);
            chk("busy", m_busy, 1);
            if (m_en) begin
                addr_q.push_back(int'(m_addr));
                chk("en_without_valid", m_valid, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_byte", m_byte, prev_byte);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid) begin
                chk("no_extra_byte", idx < nb, 1);
                chk("byte", m_byte, exp_byte(s, idx));
                chk("last", m_last, idx == nb - 1);
                prev_stall = !ready;
                prev_byte  = m_byte;
                prev_last  = m_last;
                if (ready) idx++;
                else stalls++;
            end else begin
                prev_stall = 1'b0;
            end
            if (m_done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
        end
        start = 1'b0;
        ready = 1'b1;
        chk("done_seen", got_done, 1);
        chk("done_cycle", done_cyc, 2 * nw + nb + 1 + stalls);
        chk("byte_count", idx, nb);
        chk("read_count", addr_q.size(), nw);
        for (int i = 0; i < addr_q.size(); i++) chk("read_addr", addr_q[i], i);
        @(posedge clk); #1;
        chk("busy_after_done", m_busy, 0);
        chk("done_pulse_width", m_done, 0);
        chk("valid_after_done", m_valid, 0);
    endtask

    task automatic fill_random();
        foreach (mem_a[i]) mem_a[i] = {$urandom, $urandom};
        foreach (mem_b[i]) mem_b[i] = {$urandom, $urandom};
        foreach (mem_c[i]) mem_c[i] = {$urandom, $urandom};
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b1; sel = 0;
        res_a = '0; res_b = '0; res_c = '0;
        fill_random();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_idle_outputs("reset");
        end
        rst = 1'b0;

        // Word w carries bytes 8w..8w+7, so the stream should be 0x00..0x7D.
        foreach (mem_a[w]) begin
            logic [63:0] wd;
            for (int k = 0; k < 8; k++) wd[63 - 8 * k -: 8] = 8'(8 * w + k);
            mem_a[w] = wd;
        end
        run(0, 0, 1'b0);

        fill_random();
        run(0, 1, 1'b0);
        run(0, 0, 1'b1);
        run(0, 2, 1'b0);

        // Reset in the middle of a drain, then a fresh start.
        sel = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle_outputs("mid_reset");
        repeat (8) @(posedge clk);
        run(0, 0, 1'b0);

        fill_random();
        run(2, 0, 1'b0);
        run(2, 1, 1'b0);
        run(1, 0, 1'b0);
        run(1, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mat_vec_res_reader.md
# mat_vec_res_reader

Drains the result buffer of the serial GF(256) matrix-vector multiplier once it has finished. It drives the multiplier's result-read port (`res_en` / `res_addr`, registered one-cycle read) and unpacks each PROC_SIZE-bit word into a byte stream with a valid/ready handshake. The last word's padding bytes are dropped. It sits between the multiplier and the downstream hash/commit or output logic.

## Interface
- N_GF, 8, bytes per result word
- RES_BYTES, 126, number of meaningful result bytes (L1: 126, L3: 193, L5: 278)
- PROC_SIZE, N_GF*8, result word width in bits
- N_WORDS, ceil(RES_BYTES/N_GF), words read from the result buffer
- ADDR_W, `CLOG2(N_WORDS)`, width of the result-buffer address
---
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse; begins a drain; ignored unless idle
- o_res_en  out  1  result-buffer read strobe
- o_res_addr  out  ADDR_W  result-buffer word address
- i_res  in  PROC_SIZE  read data, valid the cycle after o_res_en
- o_byte  out  8  stream data
- o_byte_valid  out  1  stream valid
- i_byte_ready  in  1  stream ready from the sink
- o_byte_last  out  1  high with the final byte (index RES_BYTES-1)
- o_busy  out  1  high from the cycle after i_start until the cycle of o_done, inclusive
- o_done  out  1  one-cycle pulse after the last byte handshake

## Operation
- The FSM has five states: IDLE, READ, LOAD, SHIFT and DONE.
- **IDLE:** i_start=1 → READ. The word counter w and the byte counter b are cleared.
- **READ:** o_res_en=1 and o_res_addr=w for exactly one cycle, then → LOAD.
- **LOAD:** i_res is captured into a PROC_SIZE shift register. The in-word counter k is set to 0. → SHIFT.
- **SHIFT:**
  - o_byte_valid=1 and o_byte = shreg[PROC_SIZE-1 -: 8]. Byte k of word w is i_res[PROC_SIZE-1-8k -: 8] and has stream index w*N_GF+k.
  - On a handshake (valid & ready) the register shifts left by 8, and k and b increment.
  - When the handshake is for b = RES_BYTES-1: o_byte_last=1 and → DONE.
  - Else when k = N_GF-1: w increments and → READ.
  - Padding bytes of the final word (k ≥ RES_BYTES - (N_WORDS-1)*N_GF) are never presented.
- **DONE:** o_done=1 for one cycle, then → IDLE.
- Stream rule: while o_byte_valid=1 and i_byte_ready=0, o_byte and o_byte_last hold stable and valid stays high.
- o_res_en is never asserted outside READ. o_res_addr holds its last value otherwise and never exceeds N_WORDS-1.
- i_start during any non-IDLE state is ignored and does not restart the drain.
- i_rst in any state forces IDLE next cycle and clears all counters and the shift register.

## Timing
- Reset values: all outputs are 0 (o_res_addr=0, o_byte=0).
- Cycle numbering: i_start is high in cycle 0. READ of word 0 is in cycle 1; LOAD is in cycle 2; the first byte is valid in cycle 3.
- Per-word overhead is 2 cycles (READ, LOAD). There is no prefetch.
- With i_byte_ready held at 1:
  - the last handshake is in cycle 2*N_WORDS + RES_BYTES;
  - o_done is in cycle 2*N_WORDS + RES_BYTES + 1.
  - Example: defaults (N_WORDS=16, RES_BYTES=126) give the last byte in cycle 158 and o_done in cycle 159.
- Each cycle i_byte_ready is low during SHIFT adds exactly one cycle to the total.
- o_byte_valid has no combinational path from i_byte_ready.

## Structure
- A shared package holds:
  - the state encoding (IDLE/READ/LOAD/SHIFT/DONE);
  - the N_WORDS and LAST_WORD_BYTES = RES_BYTES - (N_WORDS-1)*N_GF derivation functions;
  - the PARAMETER_SET → RES_BYTES mapping (L1/L3/L5).
- `CLOG2` comes from the common defines header.
- The block is one flat module. A sub-module is not warranted: the shift register and counters are a few lines each.

## Test plan
- **Defaults, ready=1, word w filled with bytes 8w..8w+7, MSB first:**
  - the stream is 0x00..0x7D, 126 bytes;
  - o_byte_last only on 0x7D;
  - o_done in cycle 159;
  - o_res_addr covers 0..15 once each;
  - bytes 0x7E/0x7F are never emitted.
- **Ready toggled 1,0,1,0…:**
  - identical byte sequence;
  - data stable across every stalled cycle;
  - o_done delayed by exactly the number of stalled SHIFT cycles.
- **i_start re-pulsed in cycles 5 and 40:**
  - no effect on addresses, stream or o_done timing.
- **i_rst asserted in cycle 50, then i_start at cycle 60:**
  - all outputs are 0 from cycle 51;
  - the fresh drain restarts at address 0 with byte 0x00;
  - o_done arrives 159 cycles after the new start.
- **RES_BYTES=8, N_GF=8 (exact fit):**
  - one READ, 8 bytes, last on byte 7;
  - o_done in cycle 11.
- **RES_BYTES=193, ready=1:**
  - 25 reads;
  - the final word yields 1 byte;
  - o_done in cycle 244.
